attention_exp_row_streamer: RTL and testbench
=============================================

ATTENTION_EXP_ROW_STREAMER -- requirements
Module: attention_exp_row_streamer

Interface
REQ-001 SHALL have parameter T, default 4, meaning sequence length (exp matrix is T x T).
REQ-002 SHALL have parameter DATA_W, default 32, meaning fp32 word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries (power of 2, >=2).
REQ-004 SHALL have parameter TO_CYCLES, default 64, meaning read-response timeout (used only with the macro in REQ-028).
REQ-005 SHALL have port clk  input  1  clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports start input 1 (begin scan pulse); busy output 1; done output 1 (one-cycle completion pulse).
REQ-008 SHALL have ports exp_re output 1, exp_tq output T_W, exp_tk output T_W (T_W = clog2(T), min 1): exp matrix read request.
REQ-009 SHALL have ports exp_rdata input DATA_W, exp_rvalid input 1: read response.
REQ-010 SHALL have ports m_valid output 1, m_ready input 1, m_data output DATA_W, m_tq output T_W, m_tk output T_W, m_last_col output 1 (tk==T-1), m_last_row output 1 (tq==T-1 and tk==T-1).

Function
REQ-011 SHALL be the initiator of the exp read interface, scanning all T*T entries row-major (tq outer, tk inner) and streaming them out over valid/ready.
REQ-012 SHALL use states IDLE, REQ, WAIT, DRAIN; IDLE->REQ on start; REQ->WAIT after issuing a request; WAIT->REQ on exp_rvalid if entries remain, else WAIT->DRAIN; DRAIN->IDLE when FIFO empty.
REQ-013 SHALL drive exp_re as a single-cycle pulse in REQ with exp_tq/exp_tk stable from that cycle until the matching exp_rvalid.
REQ-014 SHALL keep at most one read outstanding; exp_rvalid outside WAIT SHALL be ignored.
REQ-015 SHALL issue a request only when FIFO count + outstanding < FIFO_DEPTH; otherwise remain in REQ with exp_re low.
REQ-016 SHALL push {exp_rdata, tq, tk} into the FIFO in the cycle exp_rvalid is seen in WAIT; minimum request-to-request spacing 2 cycles for 1-cycle read latency.
REQ-017 SHALL present the FIFO head on m_* with m_valid high whenever FIFO non-empty; pop on m_valid && m_ready; m_* SHALL stay stable while m_valid && !m_ready.
REQ-018 SHALL support push and pop in the same cycle with count unchanged, including when full (pop frees the slot first).
REQ-019 SHALL wrap FIFO pointers modulo FIFO_DEPTH; tk index SHALL wrap T-1->0 incrementing tq; after (T-1,T-1) no further requests.
REQ-020 SHALL assert busy from the cycle after start until done; start while busy SHALL be ignored.
REQ-021 SHALL pulse done for one cycle on the cycle after the last beat (m_last_row) is popped.
REQ-022 SHALL produce exactly T*T output beats per start, in row-major order, with no duplicates or drops under arbitrary m_ready backpressure.

Reset
REQ-023 SHALL, on rst_n high, asynchronously force state IDLE, FIFO empty, counters zero.
REQ-024 SHALL reset outputs: busy 0, done 0, exp_re 0, exp_tq 0, exp_tk 0, m_valid 0, m_data 0, m_tq 0, m_tk 0, m_last_col 0, m_last_row 0.
REQ-025 SHALL discard any in-flight request and buffered data on reset mid-scan; a late exp_rvalid after reset SHALL be ignored.
REQ-026 SHALL resume normal operation on the first rising clk edge after rst_n falls.

Configuration
REQ-027 SHALL compile a response timeout only when macro ATTN_EXP_STREAM_TIMEOUT_EN is defined.
REQ-028 With ATTN_EXP_STREAM_TIMEOUT_EN: output err_timeout (1 bit, reset 0); if WAIT lasts TO_CYCLES cycles without exp_rvalid, SHALL set err_timeout sticky, push no data, go to DRAIN, then IDLE and pulse done; err_timeout clears on next accepted start.
REQ-029 Without ATTN_EXP_STREAM_TIMEOUT_EN: no err_timeout port, WAIT has no bound.

Verification
REQ-030 T=4, responder returns exp[tq][tk]=32'h3F800000+(tq*4+tk) 1 cycle after exp_re, m_ready=1 -> 16 beats in order (0,0)..(3,3), m_last_col at tk=3, m_last_row only on beat 16, done pulses once.
REQ-031 Same, m_ready low for 20 cycles after start -> exactly FIFO_DEPTH=4 requests issued then exp_re stays 0; releasing m_ready yields all 16 beats unchanged.
REQ-032 Random m_ready (50%) and read latency 1..5 cycles -> 16 beats, data matches model, never >1 outstanding, m_* stable under stall.
REQ-033 Second start pulse during busy -> ignored, still exactly 16 beats and one done.
REQ-034 Assert rst_n high after beat 6 with a read outstanding -> all outputs reset values next cycle; new start gives full 16-beat scan from (0,0).
REQ-035 With ATTN_EXP_STREAM_TIMEOUT_EN, responder withholds exp_rvalid for (1,2) -> err_timeout=1 after 64 WAIT cycles, beats (0,0)..(1,1) delivered only, done pulses.

Source files
------------

// File: rtl/attention_exp_row_streamer.sv
// rtl/attention_exp_row_streamer.sv - row-major exp matrix reader streaming entries out through a small output FIFO
// Optional feature macro: ATTN_EXP_STREAM_TIMEOUT_EN (read-response timeout with sticky err_timeout)
module attention_exp_row_streamer #(
    parameter int T          = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TO_CYCLES  = 64,
    localparam int T_W       = (T > 1) ? $clog2(T) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              exp_re,
    output logic [T_W-1:0]    exp_tq,
    output logic [T_W-1:0]    exp_tk,
    input  logic [DATA_W-1:0] exp_rdata,
    input  logic              exp_rvalid,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [T_W-1:0]    m_tq,
    output logic [T_W-1:0]    m_tk,
    output logic              m_last_col,
`ifdef ATTN_EXP_STREAM_TIMEOUT_EN
    output logic              err_timeout,
`endif
    output logic              m_last_row
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [T_W-1:0] T_LAST  = T_W'(T - 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

    // Reject configurations the pointer arithmetic cannot handle
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TO_CYCLES < 1) begin : g_bad_timeout
        $error("TO_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state;

    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [T_W-1:0]    fifo_tq   [FIFO_DEPTH];
    logic [T_W-1:0]    fifo_tk   [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     next_count;

    logic push;
    logic pop;
    logic last_req;

    // A read is only accepted while waiting for it, so stray or late responses never reach the FIFO
    assign push     = (state == WAIT) && exp_rvalid;
    assign pop      = m_valid && m_ready;
    assign last_req = (exp_tq == T_LAST) && (exp_tk == T_LAST);

    // In REQ nothing is outstanding, so a free FIFO slot alone reserves room for the response
    assign exp_re = (state == REQ) && (count < DEPTH_C);

    assign m_valid    = (count != '0);
    assign m_data     = m_valid ? fifo_data[rd_ptr] : '0;
    assign m_tq       = m_valid ? fifo_tq[rd_ptr] : '0;
    assign m_tk       = m_valid ? fifo_tk[rd_ptr] : '0;
    assign m_last_col = m_valid && (fifo_tk[rd_ptr] == T_LAST);
    assign m_last_row = m_last_col && (fifo_tq[rd_ptr] == T_LAST);

    // Occupancy after this cycle's push/pop; simultaneous push and pop leave it unchanged
    always_comb begin
        next_count = count;
        if (push && !pop) begin
            next_count = count + 1'b1;
        end else if (!push && pop) begin
            next_count = count - 1'b1;
        end
    end

`ifdef ATTN_EXP_STREAM_TIMEOUT_EN
    localparam int TOW = $clog2(TO_CYCLES + 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TO_CYCLES - 1);

    logic [TOW-1:0] to_cnt;
    logic           timeout_hit;

    assign timeout_hit = (state == WAIT) && !exp_rvalid && (to_cnt == TO_LAST);
`endif

    // FIFO storage; pointers and occupancy live in the control block so reset clears them
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= exp_rdata;
            fifo_tq[wr_ptr]   <= exp_tq;
            fifo_tk[wr_ptr]   <= exp_tk;
        end
    end

    // Scan sequencer, read index counters and FIFO bookkeeping
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            exp_tq <= '0;
            exp_tk <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
`ifdef ATTN_EXP_STREAM_TIMEOUT_EN
            to_cnt      <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            done  <= 1'b0;
            count <= next_count;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= REQ;
                        busy   <= 1'b1;
                        exp_tq <= '0;
                        exp_tk <= '0;
`ifdef ATTN_EXP_STREAM_TIMEOUT_EN
                        err_timeout <= 1'b0;
`endif
                    end
                end
                REQ: begin
                    if (exp_re) begin
                        state <= WAIT;
`ifdef ATTN_EXP_STREAM_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (exp_rvalid) begin
                        if (last_req) begin
                            state  <= DRAIN;
                            exp_tq <= '0;
                            exp_tk <= '0;
                        end else begin
                            state <= REQ;
                            if (exp_tk == T_LAST) begin
                                exp_tk <= '0;
                                exp_tq <= exp_tq + 1'b1;
                            end else begin
                                exp_tk <= exp_tk + 1'b1;
                            end
                        end
                    end
`ifdef ATTN_EXP_STREAM_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state       <= DRAIN;
                        err_timeout <= 1'b1;
                        exp_tq      <= '0;
                        exp_tk      <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (next_count == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_attention_exp_row_streamer.sv
// tb/tb_attention_exp_row_streamer.sv - directed self-checking bench for attention_exp_row_streamer
module tb_attention_exp_row_streamer;

    localparam int T      = 4;
    localparam int DATA_W = 32;
    localparam int T_W    = 2;
    localparam int NBEATS = T * T;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic              exp_re;
    logic [T_W-1:0]    exp_tq;
    logic [T_W-1:0]    exp_tk;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_rvalid;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [T_W-1:0]    m_tq;
    logic [T_W-1:0]    m_tk;
    logic              m_last_col;
    logic              m_last_row;
`ifdef ATTN_EXP_STREAM_TIMEOUT_EN
    logic              err_timeout;
`endif

    attention_exp_row_streamer #(
        .T(T), .DATA_W(DATA_W), .FIFO_DEPTH(4), .TO_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .exp_re(exp_re), .exp_tq(exp_tq), .exp_tk(exp_tk),
        .exp_rdata(exp_rdata), .exp_rvalid(exp_rvalid),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_tq(m_tq), .m_tk(m_tk), .m_last_col(m_last_col),
`ifdef ATTN_EXP_STREAM_TIMEOUT_EN
        .err_timeout(err_timeout),
`endif
        .m_last_row(m_last_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int rdy_mode  = 0;
    int lat       = 1;
    bit rand_lat  = 0;
    bit withhold  = 0;

    bit pend      = 0;
    int pend_cnt  = 0;
    logic [T_W-1:0] rq = '0;
    logic [T_W-1:0] rk = '0;

    int beat_idx  = 0;
    int done_cnt  = 0;
    int req_cnt   = 0;
    bit last_pop_prev = 0;
    bit stall_prev    = 0;
    logic [DATA_W-1:0] sv_data;
    logic [T_W-1:0]    sv_tq;
    logic [T_W-1:0]    sv_tk;
    logic              sv_lc;
    logic              sv_lr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_exp_re", exp_re, 0);
        check("rst_exp_tq", exp_tq, 0);
        check("rst_exp_tk", exp_tk, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_tq", m_tq, 0);
        check("rst_m_tk", m_tk, 0);
        check("rst_m_last_col", m_last_col, 0);
        check("rst_m_last_row", m_last_row, 0);
    endtask

    // One clock of bench activity at the falling edge: ready policy, output monitor, read responder
    task automatic tick();
        bit hold;
        @(negedge clk);
        if (rdy_mode == 2) m_ready = 1'($urandom_range(0, 1));
        else m_ready = (rdy_mode == 0);

        if (stall_prev) begin
            check("stall_data", m_data, sv_data);
            check("stall_tq", m_tq, sv_tq);
            check("stall_tk", m_tk, sv_tk);
            check("stall_flags", {m_valid, m_last_col, m_last_row}, {1'b1, sv_lc, sv_lr});
        end

        if (done) begin
            done_cnt++;
            if (!withhold) check("done_after_last_pop", last_pop_prev, 1);
        end

        last_pop_prev = 0;
        if (m_valid && m_ready) begin
            check("beat_data", m_data, 32'h3F80_0000 + beat_idx);
            check("beat_tq", m_tq, beat_idx / T);
            check("beat_tk", m_tk, beat_idx % T);
            check("beat_last_col", m_last_col, (beat_idx % T) == T - 1);
            check("beat_last_row", m_last_row, beat_idx == NBEATS - 1);
            last_pop_prev = m_last_row;
            beat_idx++;
        end
        stall_prev = m_valid && !m_ready;
        sv_data = m_data; sv_tq = m_tq; sv_tk = m_tk; sv_lc = m_last_col; sv_lr = m_last_row;

        exp_rvalid = 1'b0;
        hold = withhold && (rq == 2'd1) && (rk == 2'd2);
        if (pend && !hold) begin
            check("req_addr_stable", {exp_tq, exp_tk}, {rq, rk});
            if (pend_cnt <= 1) begin
                exp_rvalid = 1'b1;
                exp_rdata  = 32'h3F80_0000 + 32'(rq) * T + 32'(rk);
                pend       = 0;
            end else begin
                pend_cnt--;
            end
        end
        if (exp_re) begin
            check("one_outstanding", pend, 0);
            pend     = 1;
            pend_cnt = rand_lat ? $urandom_range(1, 5) : lat;
            rq       = exp_tq;
            rk       = exp_tk;
            req_cnt++;
        end
    endtask

    task automatic start_scan();
        beat_idx = 0; done_cnt = 0; req_cnt = 0; pend = 0;
        stall_prev = 0; last_pop_prev = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic finish_scan(input int nbeats);
        for (int i = 0; i < 2000 && done_cnt == 0; i++) tick();
        check("done_seen", done_cnt != 0, 1);
        repeat (4) tick();
        check("done_once", done_cnt, 1);
        check("beat_count", beat_idx, nbeats);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; m_ready = 1'b0;
        exp_rvalid = 1'b0; exp_rdata = '0;

        // Reset state
        repeat (2) tick();
        check_reset_outputs();
        rst_n = 1'b0;
        repeat (2) tick();
        check("idle_exp_re", exp_re, 0);

        // Straight scan, 1-cycle latency, always ready
        rdy_mode = 0; lat = 1; rand_lat = 0;
        start_scan();
        finish_scan(NBEATS);

        // Back-pressure: only FIFO_DEPTH reads may be issued while output is stalled
        rdy_mode = 1;
        start_scan();
        repeat (20) tick();
        check("stalled_req_count", req_cnt, 4);
        check("stalled_exp_re", exp_re, 0);
        check("stalled_m_valid", m_valid, 1);
        rdy_mode = 0;
        finish_scan(NBEATS);

        // Random ready and random read latency
        rdy_mode = 2; rand_lat = 1;
        start_scan();
        finish_scan(NBEATS);

        // Start while busy must be ignored
        rdy_mode = 2; rand_lat = 0; lat = 2;
        start_scan();
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_scan(NBEATS);

        // Reset mid-scan with a read outstanding, then a stray response, then a full scan
        rdy_mode = 0; lat = 3;
        start_scan();
        for (int i = 0; i < 500 && !(beat_idx >= 6 && pend); i++) tick();
        check("reset_point_reached", beat_idx >= 6 && pend, 1);
        rst_n = 1'b1;
        #1;
        check_reset_outputs();
        pend = 0;
        stall_prev = 0;
        tick();
        rst_n = 1'b0;
        exp_rvalid = 1'b1;
        exp_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        exp_rvalid = 1'b0;
        check("late_rvalid_ignored", m_valid, 0);
        check("late_rvalid_idle", busy, 0);
        lat = 1;
        start_scan();
        finish_scan(NBEATS);

`ifdef ATTN_EXP_STREAM_TIMEOUT_EN
        // Withheld response for (1,2): timeout, partial delivery, done
        withhold = 1; rdy_mode = 0; lat = 1;
        start_scan();
        finish_scan(6);
        check("err_timeout_set", err_timeout, 1);
        withhold = 0;
        start_scan();
        check("err_timeout_cleared", err_timeout, 0);
        finish_scan(NBEATS);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
